// File: rtl/proc_trace_pkg.sv
// ============================================================================
// Module : proc_trace_pkg
// Brief  : Shared types and constants for the processor trace monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CYC_W = 32;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ring_buffer.sv
// ============================================================================
// Module : trace_ring_buffer
// Brief  : Power-of-two ring buffer with first-word-fall-through read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_ring_buffer
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 192
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [ptr_w(DEPTH):0]  o_count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_data    = r_mem[r_head];
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && o_valid;
  // When full, a push is only accepted if the head slot is freed this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/proc_trace_monitor.sv
// ============================================================================
// Module : proc_trace_monitor
// Brief  : Cycle-limited probe monitor; logs probe changes into a ring buffer.
//          Optional macro PROC_TRACE_MASK_EN adds a per-channel compare mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module proc_trace_monitor
  import proc_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 5,
  parameter int DEPTH       = 64,
  parameter int CYCLE_LIMIT = 50
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   probe_in,
  input  logic                       arm,
`ifdef PROC_TRACE_MASK_EN
  input  logic [NUM_CH-1:0]          ch_mask,
`endif
  output logic                       running,
  output logic                       stop,
  output logic [CYC_W-1:0]           cycle_count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [ptr_w(DEPTH):0]      entries,
  output logic                       overflow
);

  localparam int PW = NUM_CH * DATA_W;
  localparam int EW = PW + CYC_W;

  state_t           r_state;
  logic [CYC_W-1:0] r_cycle;
  logic [PW-1:0]    r_last;
  logic             r_ovf;
  logic             r_running;
  logic             r_stop;

  logic [PW-1:0]    w_cmp_mask;
  logic             w_changed;
  logic             w_capture;
  logic             w_pop;
  logic             w_full;
  logic             w_drop;
  logic             w_clear;
  logic [EW-1:0]    w_head;

`ifdef PROC_TRACE_MASK_EN
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_mask
      assign w_cmp_mask[i*DATA_W +: DATA_W] = {DATA_W{ch_mask[i]}};
    end
  endgenerate
`else
  assign w_cmp_mask = '1;
`endif

  assign w_changed = |((probe_in ^ r_last) & w_cmp_mask);
  // The first RUN cycle always logs, so the trace starts with a full snapshot.
  assign w_capture = (r_state == RUN) && ((r_cycle == '0) || w_changed);
  assign w_pop     = rd_valid && rd_ready;
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_clear   = (r_state == DONE) && arm;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cycle   <= '0;
      r_last    <= '0;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_cycle   <= '0;
          end
        end
        RUN: begin
          r_cycle <= r_cycle + 1'b1;
          if (w_capture) r_last <= probe_in;
          if (w_drop)    r_ovf  <= 1'b1;
          if (r_cycle == CYC_W'(CYCLE_LIMIT - 1)) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_stop    <= 1'b1;
          end
        end
        DONE: begin
          if (arm) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_stop    <= 1'b0;
            r_cycle   <= '0;
            r_ovf     <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_stop    <= 1'b0;
        end
      endcase
    end
  end

  trace_ring_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ring (
    .clk     (clock),
    .rst     (reset),
    .i_clr   (w_clear),
    .i_push  (w_capture),
    .i_data  ({probe_in, r_cycle}),
    .i_pop   (rd_ready),
    .o_data  (w_head),
    .o_valid (rd_valid),
    .o_full  (w_full),
    .o_count (entries)
  );

  assign running     = r_running;
  assign stop        = r_stop;
  assign cycle_count = r_cycle;
  assign overflow    = r_ovf;
  assign rd_data     = w_head[EW-1:CYC_W];
  assign rd_cycle    = w_head[CYC_W-1:0];

endmodule

`default_nettype wire

// File: doc/proc_trace_monitor.md
Name: proc_trace_monitor

Overview:
- Synthesizable, parametrised successor to the processor bench's cycle-limited run-and-monitor flow.
- Samples NUM_CH probe words from the processor each cycle and records an entry only when any probe changes, in $monitor style.
- Stops after CYCLE_LIMIT cycles and drains captured entries through a valid/ready read port.
- Sits beside the processor in the skeleton, wired to internal pipeline signals such as pc, o_xm, b_xm and d_mw.

Parameters:
- DATA_W, 32, width of each probe channel.
- NUM_CH, 5, number of probe channels.
- DEPTH, 64, trace buffer entries; must be a power of two, at least 2.
- CYCLE_LIMIT, 50, number of RUN cycles before auto-stop; must be at least 1.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- probe_in  in  NUM_CH*DATA_W  concatenated probes; channel 0 is bits [DATA_W-1:0].
- arm  in  1  single-cycle start pulse.
- running  out  1  high while in RUN.
- stop  out  1  high while in DONE.
- cycle_count  out  32  number of RUN cycles elapsed.
- rd_valid  out  1  buffer holds at least one entry.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  NUM_CH*DATA_W  head entry probe snapshot.
- rd_cycle  out  32  cycle_count value at which the head entry was captured.
- entries  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one change was dropped.

Behaviour:
- Reset values: state IDLE; running=0, stop=0, cycle_count=0, rd_valid=0, entries=0, overflow=0. Pointers and the last-captured register are cleared. rd_data and rd_cycle are don't-care while rd_valid=0.
- Reset mid-RUN discards all entries and the count.
- State machine:
  - IDLE: arm moves to RUN next cycle.
  - RUN: cycle_count increments every cycle. In the RUN cycle where cycle_count==CYCLE_LIMIT-1, that cycle's sample is processed normally and the state moves to DONE. cycle_count becomes CYCLE_LIMIT and then holds.
  - DONE: stop=1. arm clears the buffer, cycle_count and overflow, then enters RUN.
  - arm while in RUN is ignored.
- Capture rule in RUN:
  - Capture when the cycle is the first RUN cycle, or probe_in != last_captured (full-width compare).
  - A capture writes {probe_in, cycle_count} at the tail and updates last_captured.
  - The write is visible on rd_valid/rd_data the next cycle (1-cycle latency).
- Read port:
  - First-word-fall-through: rd_data and rd_cycle reflect the head while rd_valid=1.
  - A pop occurs when rd_valid&&rd_ready.
  - Reads are allowed in every state, including RUN.
- Full buffer:
  - A capture while entries==DEPTH and no simultaneous pop is dropped and sets overflow. last_captured is still updated, so an unchanged value does not retry.
  - A simultaneous pop and capture when full is accepted; entries is unchanged.
- Empty buffer: rd_ready while rd_valid=0 has no effect.
- Pointers wrap modulo DEPTH.
- entries is updated as +1 on capture only, -1 on pop only, unchanged on both.

Optional Feature:
- PROC_TRACE_MASK_EN defined:
  - Adds input ch_mask [NUM_CH]. Channels whose mask bit is 0 are excluded from the change compare but still stored in every entry.
  - The first-cycle capture is unaffected.
- Not defined: no ch_mask port; all channels are compared.

Decomposition:
- Package proc_trace_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - PTR_W = $clog2(DEPTH) function/constant;
  - CYC_W = 32.
- One sub-module, trace_ring_buffer: DEPTH x (NUM_CH*DATA_W+32) storage with push/pop, full, empty, count and FWFT read.
- The FSM, cycle counter, change detect and overflow logic stay in proc_trace_monitor.

Test Plan:
- Reset, then arm; hold probe constant 0x10 for 50 cycles. Expect exactly 1 entry (rd_cycle=0), stop=1 at cycle 50, cycle_count=50.
- Increment channel 0 (pc) by 4 every cycle, with no reads, DEPTH=64, CYCLE_LIMIT=50. Expect entries=50 and rd_cycle sequence 0..49 on drain, with rd_data ch0 = 0,4,...,196.
- DEPTH=8, probe changes every cycle, no reads. Expect entries=8, overflow=1, and drained rd_cycle 0..7.
- Full buffer (DEPTH=8) with rd_ready=1 while capturing. Expect entries to stay at 8, no overflow, and rd_cycle continuing without gaps.
- Assert reset at cycle 20 of RUN. Expect entries=0, rd_valid=0, state IDLE; a new arm then restarts with cycle_count from 0.
- With PROC_TRACE_MASK_EN, ch_mask=5'b00001: changes only on channel 3 produce no entries after the first; a change on channel 0 produces one entry.
